// File: rtl/if_stage_fetch.sv
// ----------------------------------------------------------------------------
// if_stage_fetch
//
// Instruction-fetch stage feeding decode. Keeps the fetch PC, issues word
// fetches to instruction memory over a req/gnt + rvalid handshake with at most
// one request in flight, buffers returned words in a small FIFO and presents
// the head entry to decode as {instruction, PC+4, valid}. A taken branch
// flushes the buffer, retargets the PC and discards any in-flight response.
//
// Parameters
//   DEPTH     prefetch buffer entries (2 or 4)
//   RESET_PC  fetch PC after reset
//
// Ports
//   clk           stage clock, rising-edge
//   rst           asynchronous active-low reset
//   freeze        decode hazard stall, holds the head entry
//   branch_taken  redirect request from execute
//   branch_addr   redirect target (word aligned)
//   imem_req      fetch request valid
//   imem_addr     fetch address
//   imem_gnt      memory accepts the request this cycle
//   imem_rvalid   response valid
//   imem_rdata    response instruction word
//   instruction   head-of-buffer instruction (0 when empty)
//   pc_out        head-of-buffer address + 4 (0 when empty)
//   inst_valid    buffer non-empty and no redirect this cycle
// ----------------------------------------------------------------------------
module if_stage_fetch #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        inst_valid
);

  localparam int unsigned     PTR_W   = (DEPTH == 4) ? 2 : 1;
  localparam int unsigned     CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE, // nothing in flight
    ST_WAIT, // one request in flight, its response will be kept
    ST_DROP  // one request in flight, its response is stale
  } state_e;

  state_e             state_q,    state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        req_addr_q, req_addr_d;
  logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [CNT_W-1:0]   count_q,    count_d;

  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc4_mem  [DEPTH];

  logic empty;
  logic pop;
  logic push;
  logic grant;
  logic slot_free;

  // --------------------------------------------------------------------------
  // Handshake and buffer control
  // --------------------------------------------------------------------------
  assign empty      = (count_q == '0);
  assign inst_valid = !empty && !branch_taken;
  assign pop        = inst_valid && !freeze;

  // A pop in this cycle frees a slot, so a full buffer that is draining may
  // still issue the next fetch back-to-back.
  assign slot_free  = (count_q - CNT_W'(pop)) < DEPTH_C;

  // rst gates the request so nothing is presented to memory while held in reset.
  assign imem_req   = rst && (state_q == ST_IDLE) && !branch_taken && slot_free;
  assign imem_addr  = fetch_pc_q;
  assign grant      = imem_req && imem_gnt;

  // A branch in the response cycle makes that response stale.
  assign push       = (state_q == ST_WAIT) && imem_rvalid && !branch_taken;

  // Outputs come only from stored entries, never straight from imem_rdata.
  assign instruction = empty ? 32'h0 : inst_mem[rd_ptr_q];
  assign pc_out      = empty ? 32'h0 : pc4_mem[rd_ptr_q];

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

    if (grant) begin
      fetch_pc_d = fetch_pc_q + 32'd4;   // wraps naturally at 2^32
      req_addr_d = fetch_pc_q;           // tag for the PC+4 of this response
    end
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (grant) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (branch_taken) begin
          // When the response lands in the branch cycle itself it is dropped
          // right here; nothing remains in flight, so there is nothing left
          // for DROP to wait for and the FSM returns straight to IDLE.
          state_d = imem_rvalid ? ST_IDLE : ST_DROP;
        end else if (imem_rvalid) begin
          state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (imem_rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Redirect wins over everything else: flush and retarget.
    if (branch_taken) begin
      fetch_pc_d = branch_addr;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: the entry storage has no reset; the count gates every read, so stale
  // contents are never visible and the array can map onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= imem_rdata;
      pc4_mem[wr_ptr_q]  <= req_addr_q + 32'd4;
    end
  end

  // --------------------------------------------------------------------------
  // Checks
  // --------------------------------------------------------------------------
  // Issue is throttled by slot_free, so a push into a full buffer without a
  // matching pop means the throttle is broken.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && (count_q == DEPTH_C)));

  // A request is only ever issued from IDLE, so at most one is in flight.
  a_single_outstanding: assert property (@(posedge clk) disable iff (!rst)
    imem_req |-> (state_q == ST_IDLE));

endmodule

// File: tb/tb_if_stage_fetch.sv
module tb_if_stage_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        inst_valid;

  int n_cmp = 0;
  int n_bad = 0;

  if_stage_fetch #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instruction  (instruction),
    .pc_out       (pc_out),
    .inst_valid   (inst_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Vector table: one record per clock cycle, inputs driven at the falling
  // edge, outputs compared 1ns later.
  // --------------------------------------------------------------------------
  typedef struct {
    logic        frz;
    logic        br;
    logic [31:0] baddr;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_ins;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic frz, input logic br, input logic [31:0] baddr,
                     input logic gnt, input logic rv, input logic [31:0] rdata,
                     input logic e_req, input logic [31:0] e_addr, input logic e_val,
                     input logic [31:0] e_ins, input logic [31:0] e_pc);
    vec_t v;
    v.frz = frz; v.br = br; v.baddr = baddr; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val; v.e_ins = e_ins; v.e_pc = e_pc;
    vecs.push_back(v);
  endtask

  // --------------------------------------------------------------------------
  // Small memory model for the multi-cycle sequences: grants every request,
  // answers LAT cycles after the grant with rdata = addr ^ A5A5_0000. A
  // scoreboard follows the expected delivery order.
  // --------------------------------------------------------------------------
  logic        m_pending, m_gnt_prev, m_rv_prev;
  int          m_wait;
  logic [31:0] m_addr, m_gaddr;
  logic [31:0] sb_addr;
  int          n_grants, n_deliv;

  task automatic mem_cycle(input logic frz, input int lat);
    @(negedge clk);
    if (m_rv_prev) m_pending = 1'b0;
    else if (m_pending && m_wait > 0) m_wait--;
    if (m_gnt_prev) begin
      m_pending = 1'b1;
      m_wait    = lat - 1;
      m_addr    = m_gaddr;
    end
    freeze       = frz;
    branch_taken = 1'b0;
    imem_gnt     = 1'b1;
    imem_rvalid  = m_pending && (m_wait == 0);
    imem_rdata   = imem_rvalid ? (m_addr ^ 32'hA5A5_0000) : 32'h0;
    #1;
    if (m_pending) check("single_outstanding_req", {31'b0, imem_req}, 32'h0);
    m_gnt_prev = imem_req && imem_gnt;
    m_gaddr    = imem_addr;
    m_rv_prev  = imem_rvalid;
    if (m_gnt_prev) n_grants++;
    if (inst_valid && !frz) begin
      check("order_instruction", instruction, sb_addr ^ 32'hA5A5_0000);
      check("order_pc_out", pc_out, sb_addr + 32'd4);
      sb_addr = sb_addr + 32'd4;
      n_deliv++;
    end
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    m_pending = 1'b0; m_gnt_prev = 1'b0; m_rv_prev = 1'b0; m_wait = 0;
    m_addr = '0; m_gaddr = '0; sb_addr = '0; n_grants = 0; n_deliv = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_imem_req", {31'b0, imem_req}, 32'h0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst_instruction", instruction, 32'h0);
    check("rst_pc_out", pc_out, 32'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // frz br baddr        gnt rv rdata        | req addr         val ins          pc
    add(0, 0, 32'h0,        1, 0, 32'h0,         1, 32'h0,         0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        1, 1, 32'hA5A5_0000, 0, 32'h4,         0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        1, 0, 32'h0,         1, 32'h4,         1, 32'hA5A5_0000, 32'h4);
    add(0, 0, 32'h0,        1, 1, 32'hA5A5_0004, 0, 32'h8,         0, 32'h0,        32'h0);
    add(1, 0, 32'h0,        1, 0, 32'h0,         1, 32'h8,         1, 32'hA5A5_0004, 32'h8);
    add(1, 0, 32'h0,        1, 1, 32'hA5A5_0008, 0, 32'hC,         1, 32'hA5A5_0004, 32'h8);
    add(1, 0, 32'h0,        1, 0, 32'h0,         0, 32'hC,         1, 32'hA5A5_0004, 32'h8);
    add(1, 0, 32'h0,        1, 0, 32'h0,         0, 32'hC,         1, 32'hA5A5_0004, 32'h8);
    add(0, 0, 32'h0,        1, 0, 32'h0,         1, 32'hC,         1, 32'hA5A5_0004, 32'h8);
    add(0, 0, 32'h0,        1, 1, 32'hA5A5_000C, 0, 32'h10,        1, 32'hA5A5_0008, 32'hC);
    add(0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h10,        1, 32'hA5A5_000C, 32'h10);
    add(0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h10,        0, 32'h0,        32'h0);
    // branch while WAIT, stale response three cycles later
    add(0, 0, 32'h0,        1, 0, 32'h0,         1, 32'h10,        0, 32'h0,        32'h0);
    add(0, 1, 32'h100,      0, 0, 32'h0,         0, 32'h14,        0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h100,       0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h100,       0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        1, 1, 32'hDEAD_BEEF, 0, 32'h100,       0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        1, 0, 32'h0,         1, 32'h100,       0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        1, 1, 32'h1111_1111, 0, 32'h104,       0, 32'h0,        32'h0);
    add(1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h104,       1, 32'h1111_1111, 32'h104);
    // branch with a populated buffer under freeze: valid dropped, then flushed
    add(1, 1, 32'h200,      1, 0, 32'h0,         0, 32'h104,       0, 32'h1111_1111, 32'h104);
    add(0, 0, 32'h0,        1, 0, 32'h0,         1, 32'h200,       0, 32'h0,        32'h0);
    // branch and response in the same cycle
    add(0, 1, 32'h300,      1, 1, 32'h2222_2222, 0, 32'h204,       0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        1, 0, 32'h0,         1, 32'h300,       0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        1, 1, 32'h3333_3333, 0, 32'h304,       0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h304,       1, 32'h3333_3333, 32'h304);
    add(0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h304,       0, 32'h0,        32'h0);
    // wrap at the top of the address space
    add(0, 1, 32'hFFFF_FFF8, 1, 0, 32'h0,        0, 32'h304,       0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        1, 0, 32'h0,         1, 32'hFFFF_FFF8, 0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        1, 1, 32'h44,        0, 32'hFFFF_FFFC, 0, 32'h0,        32'h0);
    add(1, 0, 32'h0,        1, 0, 32'h0,         1, 32'hFFFF_FFFC, 1, 32'h44,       32'hFFFF_FFFC);
    add(1, 0, 32'h0,        1, 1, 32'h55,        0, 32'h0,         1, 32'h44,       32'hFFFF_FFFC);
    add(0, 0, 32'h0,        1, 0, 32'h0,         1, 32'h0,         1, 32'h44,       32'hFFFF_FFFC);
    add(1, 0, 32'h0,        1, 1, 32'h66,        0, 32'h4,         1, 32'h55,       32'h0);
    add(0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h4,         1, 32'h55,       32'h0);
    add(0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h4,         1, 32'h66,       32'h4);
    add(0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h4,         0, 32'h0,        32'h0);

    // ---- directed vector table ----
    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      freeze       = vecs[i].frz;
      branch_taken = vecs[i].br;
      branch_addr  = vecs[i].baddr;
      imem_gnt     = vecs[i].gnt;
      imem_rvalid  = vecs[i].rv;
      imem_rdata   = vecs[i].rdata;
      #1;
      check($sformatf("vec%0d.imem_req", i), {31'b0, imem_req}, {31'b0, vecs[i].e_req});
      check($sformatf("vec%0d.imem_addr", i), imem_addr, vecs[i].e_addr);
      check($sformatf("vec%0d.inst_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].e_val});
      check($sformatf("vec%0d.instruction", i), instruction, vecs[i].e_ins);
      check($sformatf("vec%0d.pc_out", i), pc_out, vecs[i].e_pc);
      @(negedge clk);
    end

    // ---- freeze for 10 cycles: two grants fill the buffer, head held ----
    do_reset();
    for (int c = 0; c < 10; c++) begin
      mem_cycle(1'b1, 1);
      if (c >= 2) check("frz_head_pc_out", pc_out, 32'h4);
    end
    check("frz_grant_count", n_grants, 32'd2);
    check("frz_req_low_when_full", {31'b0, imem_req}, 32'h0);
    mem_cycle(1'b0, 1);
    check("unfrz_req_issued", {31'b0, imem_req}, 32'h1);
    check("unfrz_resume_addr", imem_addr, 32'h8);
    repeat (20) mem_cycle(1'b0, 1);
    check("unfrz_enough_delivered", {31'b0, n_deliv >= 8}, 32'h1);

    // ---- 5-cycle response latency: one request in flight, in-order ----
    do_reset();
    repeat (60) mem_cycle(1'b0, 5);
    check("lat5_enough_delivered", {31'b0, n_deliv >= 6}, 32'h1);

    // ---- reset with a request in flight, late response ignored ----
    do_reset();
    imem_gnt = 1'b1;
    #1;
    check("rstmid_first_req", {31'b0, imem_req}, 32'h1);
    check("rstmid_first_addr", imem_addr, 32'h0);
    @(negedge clk);
    imem_gnt = 1'b0;
    #1;
    check("rstmid_wait_no_req", {31'b0, imem_req}, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    check("rstmid_async_req", {31'b0, imem_req}, 32'h0);
    check("rstmid_async_addr", imem_addr, 32'h0);
    check("rstmid_async_valid", {31'b0, inst_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    #1;
    check("rstmid_late_rv_req", {31'b0, imem_req}, 32'h1);
    check("rstmid_late_rv_valid", {31'b0, inst_valid}, 32'h0);
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    #1;
    check("rstmid_after_valid", {31'b0, inst_valid}, 32'h0);
    check("rstmid_after_instruction", instruction, 32'h0);
    check("rstmid_after_pc_out", pc_out, 32'h0);
    check("rstmid_after_addr", imem_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
